// File: rtl/pcpi_mul_sched.sv
// Round-robin arbiter sharing one multi-cycle multiplier core among N_REQ PCPI ports.
// Claims custom-0 multiply insns, sequences the core and returns the result to the winner.
//
// state | meaning
// IDLE  | no owner; arbitrate among matching requesters from rr_ptr
// ISSUE | one-cycle start pulse to the core with latched operands
// WAIT  | core busy for the owner; watch done, owner drop and timeout
// RESP  | one-cycle ready/wr pulse with the captured result
// DRAIN | owner withdrew; swallow the core's pending done
module pcpi_mul_sched #(
    parameter int         N_REQ   = 4,
    parameter int         XLEN    = 32,
    parameter logic [6:0] OPCODE  = 7'b0001011,
    parameter int         TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      pcpi_valid,
    input  logic [N_REQ*32-1:0]   pcpi_insn,
    input  logic [N_REQ*XLEN-1:0] pcpi_rs1,
    input  logic [N_REQ*XLEN-1:0] pcpi_rs2,
    output logic [N_REQ-1:0]      pcpi_wait,
    output logic [N_REQ-1:0]      pcpi_ready,
    output logic [N_REQ-1:0]      pcpi_wr,
    output logic [XLEN-1:0]       pcpi_rd,
    output logic                  mul_start,
    output logic [XLEN-1:0]       mul_a,
    output logic [XLEN-1:0]       mul_b,
    output logic [1:0]            mul_variant,
    output logic [1:0]            mul_func3,
    input  logic                  mul_done,
    input  logic [XLEN-1:0]       mul_result,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [2:0]       rr_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic [XLEN-1:0]  result_q;

    logic [N_REQ-1:0] match;
    logic [N_REQ-1:0] grant_oh;
    logic [N_REQ-1:0] wait_nxt;
    logic [7:0]       match_ext;
    logic [7:0]       valid_ext;
    logic             grant_valid;

    logic             pick_found;
    logic [2:0]       pick_id;
    logic [3:0]       scan_idx;
    logic [XLEN-1:0]  pick_rs1, pick_rs2;
    logic [1:0]       pick_var, pick_f3;
    logic             insn_unused;

    assign insn_unused = ^pcpi_insn;

    always_comb begin
        match = '0;
        for (int i = 0; i < N_REQ; i++) begin
            match[i] = pcpi_valid[i]
                     && (pcpi_insn[32*i +: 7] == OPCODE)
                     && (pcpi_insn[32*i+27 +: 5] == 5'd0)
                     && !pcpi_insn[32*i+14];
        end
    end

    assign match_ext   = 8'(match);
    assign valid_ext   = 8'(pcpi_valid);
    assign grant_valid = valid_ext[grant_id];

    // Scan downwards so the lowest offset from rr_ptr is the last (winning) write.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + 4'(k);
            if (scan_idx >= 4'(N_REQ))
                scan_idx = scan_idx - 4'(N_REQ);
            if (match_ext[scan_idx[2:0]]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx[2:0];
            end
        end
    end

    always_comb begin
        pick_rs1 = '0;
        pick_rs2 = '0;
        pick_var = '0;
        pick_f3  = '0;
        grant_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_id == 3'(i)) begin
                pick_rs1 = pcpi_rs1[XLEN*i +: XLEN];
                pick_rs2 = pcpi_rs2[XLEN*i +: XLEN];
                pick_var = pcpi_insn[32*i+25 +: 2];
                pick_f3  = pcpi_insn[32*i+12 +: 2];
            end
            grant_oh[i] = (grant_id == 3'(i));
        end
    end

    // A done coinciding with the owner's drop means the core is already idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = grant_valid ? S_WAIT : S_DRAIN;
            S_WAIT: begin
                if (!grant_valid)
                    state_nxt = mul_done ? S_IDLE : S_DRAIN;
                else if (mul_done)
                    state_nxt = S_RESP;
                else if (wait_cnt == '0)
                    state_nxt = S_IDLE;
            end
            S_RESP:  state_nxt = S_IDLE;
            S_DRAIN: if (mul_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wait_nxt = match & ~(grant_oh & {N_REQ{(state == S_RESP) || (state_nxt == S_RESP)}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_variant <= '0;
            mul_func3   <= '0;
            wait_cnt    <= '0;
            result_q    <= '0;
            timeout_err <= 1'b0;
            pcpi_wait   <= '0;
        end else begin
            state     <= state_nxt;
            pcpi_wait <= wait_nxt;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_id;
                        mul_a       <= pick_rs1;
                        mul_b       <= pick_rs2;
                        mul_variant <= pick_var;
                        mul_func3   <= pick_f3;
                    end
                end
                S_ISSUE: wait_cnt <= CNT_W'(TIMEOUT - 1);
                S_WAIT: begin
                    if (grant_valid && mul_done)
                        result_q <= mul_result;
                    else if (grant_valid && (wait_cnt == '0))
                        timeout_err <= 1'b1;
                    if (wait_cnt != '0)
                        wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_RESP: rr_ptr <= (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                default: ;
            endcase
        end
    end

    assign pcpi_ready = (state == S_RESP) ? grant_oh : '0;
    assign pcpi_wr    = pcpi_ready;
    assign pcpi_rd    = (state == S_RESP) ? result_q : '0;
    assign mul_start  = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_pcpi_mul_sched.sv
// Directed bench for pcpi_mul_sched: vector table for single requests plus
// hand sequences for round-robin, withdrawal, timeout and mid-operation reset.
module tb_pcpi_mul_sched;

    localparam int         N   = 4;
    localparam int         T   = 16;
    localparam logic [6:0] OPC = 7'b0001011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  tb_valid = '0;
    logic [N*32-1:0] tb_insn = '0;
    logic [N*32-1:0] tb_rs1 = '0;
    logic [N*32-1:0] tb_rs2 = '0;
    logic [N-1:0]  pcpi_wait, pcpi_ready, pcpi_wr;
    logic [31:0]   pcpi_rd;
    logic          mul_start;
    logic [31:0]   mul_a, mul_b;
    logic [1:0]    mul_variant, mul_func3;
    logic          mul_done;
    logic [31:0]   mul_result;
    logic [2:0]    grant_id;
    logic          busy, timeout_err;

    int checks = 0;
    int errors = 0;

    int          core_lat = 0;
    int          core_cnt = 0;
    logic [31:0] core_val = '0;

    pcpi_mul_sched #(.N_REQ(N), .XLEN(32), .OPCODE(OPC), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .pcpi_valid(tb_valid), .pcpi_insn(tb_insn), .pcpi_rs1(tb_rs1), .pcpi_rs2(tb_rs2),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_variant(mul_variant), .mul_func3(mul_func3),
        .mul_done(mul_done), .mul_result(mul_result),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Stand-in core: done core_lat negedges after start; core_lat==0 never finishes.
    // Its result folds in variant/func3 so their latching shows up in rd.
    initial begin
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (rst) begin
                core_cnt = 0;
            end else begin
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        mul_done   = 1'b1;
                        mul_result = core_val;
                    end
                end
                if (mul_start && core_lat > 0) begin
                    core_cnt = core_lat;
                    core_val = mul_a * mul_b + (32'(mul_variant) << 16) + (32'(mul_func3) << 20);
                end
            end
        end
    end

    typedef struct {
        int          port;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          lat;
        bit          claim;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic load(input int p, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        tb_insn[32*p +: 32] = insn;
        tb_rs1[32*p +: 32]  = a;
        tb_rs2[32*p +: 32]  = b;
        tb_valid[p]         = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        tb_valid = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_any_ready(output int port, output logic [31:0] rd);
        port = -1;
        rd   = '0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (|pcpi_ready) begin
                for (int i = 0; i < N; i++)
                    if (pcpi_ready[i]) port = i;
                rd = pcpi_rd;
                return;
            end
        end
    endtask

    task automatic serve(input vec_t v);
        int  n;
        int  bad;
        bit  seen;
        @(negedge clk);
        core_lat = v.lat;
        load(v.port, v.insn, v.rs1, v.rs2);
        if (v.claim) begin
            @(posedge clk);
            #1;
            chk("issue_start", 32'(mul_start), 32'd1);
            chk("issue_grant", 32'(grant_id), 32'(v.port));
            chk("issue_wait", 32'(pcpi_wait), 32'(1 << v.port));
            chk("issue_variant", 32'(mul_variant), 32'(v.insn[26:25]));
            chk("issue_func3", 32'(mul_func3), 32'(v.insn[13:12]));
            seen = 1'b0;
            for (n = 2; n <= 60; n++) begin
                @(posedge clk);
                #1;
                if (|pcpi_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("ready_seen", 32'(seen), 32'd1);
            if (seen) begin
                chk("latency", n, v.lat + 2);
                chk("ready_port", 32'(pcpi_ready), 32'(1 << v.port));
                chk("wr_eq_ready", 32'(pcpi_wr), 32'(pcpi_ready));
                chk("rd", pcpi_rd, v.rd);
                chk("wait_in_resp", 32'(pcpi_wait), 32'd0);
            end
            @(negedge clk);
            tb_valid[v.port] = 1'b0;
            @(posedge clk);
            #1;
            chk("ready_pulse_end", 32'(pcpi_ready), 32'd0);
            chk("rd_cleared", pcpi_rd, 32'd0);
        end else begin
            bad = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (pcpi_wait != '0 || pcpi_ready != '0 || busy) bad++;
            end
            chk("noclaim", bad, 0);
            @(negedge clk);
            tb_valid[v.port] = 1'b0;
        end
    endtask

    initial begin
        int          p;
        int          bad;
        logic [31:0] rd;

        vecs[0] = '{0, mk(7'd0, 3'd0, OPC), 32'd7, 32'd6, 3, 1'b1, 32'd42};
        vecs[1] = '{1, mk(7'd1, 3'd1, OPC), 32'd100, 32'd200, 1, 1'b1, 32'h0011_4E20};
        vecs[2] = '{2, mk(7'd2, 3'd2, OPC), 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'h0021_FFFE};
        vecs[3] = '{3, mk(7'd3, 3'd3, OPC), 32'h0001_2345, 32'h10, 2, 1'b1, 32'h0045_3450};
        vecs[4] = '{1, mk(7'd0, 3'd0, 7'b0110011), 32'd3, 32'd3, 1, 1'b0, 32'd0};
        vecs[5] = '{1, mk(7'd0, 3'b100, OPC), 32'd3, 32'd3, 1, 1'b0, 32'd0};
        vecs[6] = '{1, mk(7'b0000100, 3'd0, OPC), 32'd3, 32'd3, 1, 1'b0, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wait", 32'(pcpi_wait), 32'd0);
        chk("rst_ready", 32'(pcpi_ready), 32'd0);
        chk("rst_rd", pcpi_rd, 32'd0);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_toerr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) serve(vecs[k]);

        // Round robin from a fresh rr_ptr: 0 then 2, then rr_ptr=3 wraps to 0 first.
        do_reset();
        core_lat = 2;
        @(negedge clk);
        load(0, mk(7'd0, 3'd0, OPC), 32'd2, 32'd3);
        load(2, mk(7'd0, 3'd0, OPC), 32'd4, 32'd5);
        @(posedge clk);
        #1;
        chk("rr_wait_both", 32'(pcpi_wait), 32'b0101);
        chk("rr_first_grant", 32'(grant_id), 32'd0);
        for (int r = 0; r < 2; r++) begin
            wait_any_ready(p, rd);
            chk("rr_a_port", p, 0);
            chk("rr_a_rd", rd, 32'd6);
            @(negedge clk);
            tb_valid[0] = 1'b0;
            wait_any_ready(p, rd);
            chk("rr_b_port", p, 2);
            chk("rr_b_rd", rd, 32'd20);
            @(negedge clk);
            tb_valid[2] = 1'b0;
            @(negedge clk);
            if (r == 0) tb_valid = 4'b0101;
        end

        // Owner withdraws during ISSUE: start still goes out, no ready follows.
        core_lat = 2;
        @(negedge clk);
        load(0, mk(7'd0, 3'd0, OPC), 32'd5, 32'd5);
        @(posedge clk);
        #1;
        chk("idrop_start", 32'(mul_start), 32'd1);
        @(negedge clk);
        tb_valid[0] = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (|pcpi_ready) bad++;
        end
        chk("idrop_noready", bad, 0);
        chk("idrop_idle", 32'(busy), 32'd0);

        // Owner withdraws during WAIT; late done is swallowed, next request gets its own rd.
        core_lat = 6;
        @(negedge clk);
        load(3, mk(7'd0, 3'd0, OPC), 32'd9, 32'd9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tb_valid[3] = 1'b0;
        @(posedge clk);
        #1;
        chk("wdrop_wait_clr", 32'(pcpi_wait), 32'd0);
        chk("wdrop_drain_busy", 32'(busy), 32'd1);
        bad = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (|pcpi_ready) bad++;
        end
        chk("wdrop_noready", bad, 0);
        chk("wdrop_idle", 32'(busy), 32'd0);
        serve('{1, mk(7'd0, 3'd0, OPC), 32'd3, 32'd5, 2, 1'b1, 32'd15});

        // Core never answers: abort after T WAIT cycles with sticky timeout_err.
        core_lat = 0;
        @(negedge clk);
        load(2, mk(7'd0, 3'd0, OPC), 32'd8, 32'd8);
        bad = 0;
        repeat (T + 1) begin
            @(posedge clk);
            #1;
            if (|pcpi_ready) bad++;
        end
        chk("to_err_pre", 32'(timeout_err), 32'd0);
        chk("to_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        tb_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("to_sticky", 32'(timeout_err), 32'd1);
        chk("to_noready", bad, 0);

        // Reset while in WAIT clears everything, including timeout_err.
        core_lat = 0;
        @(negedge clk);
        load(2, mk(7'd1, 3'd2, OPC), 32'd11, 32'd13);
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_pre_grant", 32'(grant_id), 32'd2);
        chk("mrst_pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        tb_valid = '0;
        @(posedge clk);
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_grant", 32'(grant_id), 32'd0);
        chk("mrst_wait", 32'(pcpi_wait), 32'd0);
        chk("mrst_ready", 32'(pcpi_ready | pcpi_wr), 32'd0);
        chk("mrst_rd", pcpi_rd, 32'd0);
        chk("mrst_start", 32'(mul_start), 32'd0);
        chk("mrst_ops", mul_a | mul_b, 32'd0);
        chk("mrst_varf3", 32'({mul_variant, mul_func3}), 32'd0);
        chk("mrst_toerr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
